// File: rtl/key_conditioner.sv
// Panel push-button conditioner: 2-flop synchroniser, debounce, press/release/long-press pulses.
// Long-press logic is built only when KEY_LONGPRESS_EN is defined. The release output is named key_release because "release" is a reserved word.
module key_conditioner #(
  parameter int N_KEYS          = 5,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 100000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_KEYS-1:0] raw_key,
  output logic [N_KEYS-1:0] level,
  output logic [N_KEYS-1:0] press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] long_press
);

  localparam int DW = ($clog2(DEBOUNCE_CYCLES) > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [N_KEYS-1:0] s1_p0;
  logic [N_KEYS-1:0] s2_p1;
  logic [DW-1:0]     dcnt [N_KEYS];
  logic [N_KEYS-1:0] accept;

  always_comb begin
    accept = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      accept[i] = (s2_p1[i] != level[i]) && (dcnt[i] == D_LAST);
    end
  end

  // stage p0/p1: synchroniser; then debounce and edge pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_p0       <= '0;
      s2_p1       <= '0;
      level       <= '0;
      press       <= '0;
      key_release <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        dcnt[i] <= '0;
      end
    end else begin
      s1_p0       <= raw_key;
      s2_p1       <= s1_p0;
      press       <= accept & s2_p1;
      key_release <= accept & ~s2_p1;
      for (int i = 0; i < N_KEYS; i++) begin
        if (s2_p1[i] == level[i]) begin
          dcnt[i] <= '0;
        end else if (accept[i]) begin
          level[i] <= s2_p1[i];
          dcnt[i]  <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + DW'(1);
        end
      end
    end
  end

`ifdef KEY_LONGPRESS_EN
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] H_MAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] H_FIRE = HW'(LONG_CYCLES - 1);

  logic [HW-1:0] hcnt [N_KEYS];

  // hold stage: hcnt saturates at LONG_CYCLES so the pulse cannot repeat; a falling level wins over long_press
  always_ff @(posedge clk) begin
    if (reset) begin
      long_press <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        hcnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        long_press[i] <= level[i] && (hcnt[i] == H_FIRE) && !accept[i];
        if (!level[i]) begin
          hcnt[i] <= '0;
        end else if (hcnt[i] != H_MAX) begin
          hcnt[i] <= hcnt[i] + HW'(1);
        end
      end
    end
  end
`else
  // always zero in this build
  assign long_press = {N_KEYS{LONG_CYCLES < 0}};
`endif

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: directed scenarios plus randomized key activity
// compared every cycle against a sample-window reference model.
module tb_key_conditioner;
  localparam int NK  = 5;
  localparam int DEB = 4;
  localparam int LNG = 10;
  localparam int HMAX = 4096;

  logic          clk = 1'b0;
  logic          reset;
  logic [NK-1:0] raw_key;
  logic [NK-1:0] level, press, key_release, long_press;

  key_conditioner #(.N_KEYS(NK), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LNG)) dut (
    .clk(clk), .reset(reset), .raw_key(raw_key),
    .level(level), .press(press), .key_release(key_release), .long_press(long_press)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int edgeCnt = 0;

  // reference model state: raw sample seen at each edge, accepted level, press timestamp
  logic [NK-1:0] hist [0:HMAX-1];
  logic [NK-1:0] mLevel;
  logic [NK-1:0] expPress, expRel, expLong;
  int pressEdge [NK];

  int obsPress [NK], obsRel [NK], obsLong [NK];
  int cntPress [NK], cntRel [NK], cntLong [NK];

  task automatic checkVec(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, edgeCnt, obs, exp);
    end
  endtask

  task automatic checkInt(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // level flips once the last DEB synchronised samples (raw delayed by two edges) all disagree with it
  function automatic bit windowAll(input int i, input int e, input logic v);
    bit ok = 1'b1;
    for (int k = 2; k <= DEB + 1; k++) begin
      logic s;
      s = (e - k >= 0) ? hist[e-k][i] : 1'b0;
      if (s !== v) ok = 1'b0;
    end
    return ok;
  endfunction

  task automatic modelEdge(input logic [NK-1:0] v, input logic r);
    int e = edgeCnt;
    expPress = '0; expRel = '0; expLong = '0;
    hist[e] = v;
    if (r) begin
      hist[e] = '0;
      if (e > 0) hist[e-1] = '0;
      mLevel = '0;
      for (int i = 0; i < NK; i++) pressEdge[i] = -100000;
    end else begin
      for (int i = 0; i < NK; i++) begin
        logic oldLevel;
        bit fall;
        oldLevel = mLevel[i];
        fall = 1'b0;
        if (windowAll(i, e, ~oldLevel)) begin
          if (oldLevel == 1'b0) begin
            expPress[i] = 1'b1;
            pressEdge[i] = e;
          end else begin
            expRel[i] = 1'b1;
            fall = 1'b1;
          end
          mLevel[i] = ~oldLevel;
        end
`ifdef KEY_LONGPRESS_EN
        if (oldLevel && !fall && (e == pressEdge[i] + LNG)) expLong[i] = 1'b1;
`endif
      end
    end
  endtask

  task automatic step(input logic [NK-1:0] v, input logic r);
    raw_key = v;
    reset = r;
    @(posedge clk);
    modelEdge(v, r);
    #1;
    checkVec("level", level, mLevel);
    checkVec("press", press, expPress);
    checkVec("release", key_release, expRel);
    checkVec("long_press", long_press, expLong);
    for (int i = 0; i < NK; i++) begin
      if (press[i] === 1'b1) begin obsPress[i] = edgeCnt; cntPress[i]++; end
      if (key_release[i] === 1'b1) begin obsRel[i] = edgeCnt; cntRel[i]++; end
      if (long_press[i] === 1'b1) begin obsLong[i] = edgeCnt; cntLong[i]++; end
    end
    edgeCnt++;
  endtask

  task automatic clearObs();
    for (int i = 0; i < NK; i++) begin
      obsPress[i] = -1; obsRel[i] = -1; obsLong[i] = -1;
      cntPress[i] = 0; cntRel[i] = 0; cntLong[i] = 0;
    end
  endtask

  initial begin
    int t0;
    int rEdge;
    logic [NK-1:0] rs;
    for (int k = 0; k < HMAX; k++) hist[k] = '0;
    mLevel = '0;
    for (int i = 0; i < NK; i++) pressEdge[i] = -100000;
    clearObs();
    raw_key = '0;
    reset = 1'b1;

    // reset state
    repeat (3) step('0, 1'b1);
    checkVec("reset_outputs", level | press | key_release | long_press, '0);

    // clean press and release on key 0
    clearObs();
    t0 = edgeCnt;
    repeat (12) step(5'b00001, 1'b0);
    checkInt("clean_press_latency", obsPress[0] - t0, DEB + 1);
    checkInt("clean_press_count", cntPress[0], 1);
    checkInt("clean_other_keys", cntPress[1] + cntPress[2] + cntPress[3] + cntPress[4], 0);
    t0 = edgeCnt;
    repeat (8) step('0, 1'b0);
    checkInt("clean_release_latency", obsRel[0] - t0, DEB + 1);

    // bounce rejection on key 1: 3 high, 1 low, for 20 cycles
    clearObs();
    for (int c = 0; c < 20; c++) step(((c % 4) != 3) ? 5'b00010 : 5'b00000, 1'b0);
    repeat (8) step('0, 1'b0);
    checkInt("bounce_press_count", cntPress[1], 0);
    checkInt("bounce_release_count", cntRel[1], 0);

    // long press on key 2
    clearObs();
    repeat (30) step(5'b00100, 1'b0);
    checkInt("long_press_count_press", cntPress[2], 1);
`ifdef KEY_LONGPRESS_EN
    checkInt("long_latency", obsLong[2] - obsPress[2], LNG);
    checkInt("long_count", cntLong[2], 1);
`else
    checkInt("long_buildout_count", cntLong[2], 0);
`endif
    t0 = edgeCnt;
    repeat (8) step('0, 1'b0);
    checkInt("long_release_latency", obsRel[2] - t0, DEB + 1);

    // release coincides with long-press firing on key 3
    clearObs();
    t0 = edgeCnt;
    repeat (10) step(5'b01000, 1'b0);
    repeat (12) step('0, 1'b0);
    checkInt("rvl_press_latency", obsPress[3] - t0, DEB + 1);
    checkInt("rvl_release_at_long", obsRel[3] - obsPress[3], LNG);
    checkInt("rvl_no_long", cntLong[3], 0);

    // reset while key 4 debounce count is 2, raw held
    clearObs();
    repeat (4) step(5'b10000, 1'b0);
    rEdge = edgeCnt;
    step(5'b10000, 1'b1);
    checkVec("reset_mid_outputs", level | press | key_release | long_press, '0);
    repeat (10) step(5'b10000, 1'b0);
    checkInt("reset_mid_press_latency", obsPress[4] - rEdge, DEB + 2);
    checkInt("reset_mid_press_count", cntPress[4], 1);
    repeat (8) step('0, 1'b0);

    // randomized key activity: fast toggling first, then long holds, one reset in between
    rs = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NK; i++) begin
        if ($urandom_range(0, (c < 200) ? 7 : 24) == 0) rs[i] = ~rs[i];
      end
      step(rs, (c == 250) ? 1'b1 : 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
